// File: rtl/hv_pkg.sv
// rtl/hv_pkg.sv - shared widths and NTSC/PAL raster constants for the H/V counters
package hv_pkg;

  localparam int HV_W         = 9;
  localparam int NTSC_H_TOTAL = 341;
  localparam int NTSC_V_TOTAL = 262;
  localparam int PAL_H_TOTAL  = 341;
  localparam int PAL_V_TOTAL  = 312;
  localparam int NTSC_SKIP_H  = 339;

  function automatic logic [HV_W-1:0] hv_val(input int x);
    return x[HV_W-1:0];
  endfunction

endpackage

// File: rtl/hv_wrap_counter.sv
// rtl/hv_wrap_counter.sv - counter with clear, load and wrap-to-zero at LIMIT
module hv_wrap_counter
  import hv_pkg::*;
#(
  parameter int LIMIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [HV_W-1:0] load_val,
  input  logic            inc,
  output logic [HV_W-1:0] value,
  output logic            wrap
);

  localparam logic [HV_W-1:0] LIM = hv_val(LIMIT);

  // Strobe only for a genuine roll-over, not when a clear or load wins.
  assign wrap = ~rst & ~clr & ~load & inc & (value == LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= (value == LIM) ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/hv_counters.sv
// rtl/hv_counters.sv - PPU H/V raster counters; HV_ODD_SKIP_EN enables odd-frame dot skip
module hv_counters
  import hv_pkg::*;
#(
  parameter int H_TOTAL = NTSC_H_TOTAL,
  parameter int V_TOTAL = NTSC_V_TOTAL,
  parameter int SKIP_H  = NTSC_SKIP_H
) (
  input  logic            PCLK,
  input  logic            RES,
  input  logic            HC,
  input  logic            VC,
  input  logic            BLNK,
  output logic [HV_W-1:0] H_out,
  output logic [HV_W-1:0] V_out,
  output logic            ODD,
  output logic            HEND,
  output logic            VEND
);

  localparam logic [HV_W-1:0] H_LAST  = hv_val(H_TOTAL - 1);
  localparam logic [HV_W-1:0] V_LAST  = hv_val(V_TOTAL - 1);
  localparam logic [HV_W-1:0] SKIP_AT = hv_val(SKIP_H - 1);
  localparam logic [HV_W-1:0] SKIP_TO = hv_val(SKIP_H + 1);
  // Skipping the final dot leaves nothing to jump to, so the skip just ends the line.
  localparam bit SKIP_ENDS_LINE = (SKIP_H + 1 >= H_TOTAL);

  logic skip_line;
  logic skip_hit;
  logic skip_jump;
  logic skip_end;
  logic h_last;
  logic v_wrap;
  logic unused_h_wrap;

`ifdef HV_ODD_SKIP_EN
  assign skip_line = (V_out == V_LAST) & ODD & ~BLNK;
`else
  logic unused_blnk;
  assign unused_blnk = BLNK;
  assign skip_line   = 1'b0;
`endif

  assign skip_hit  = skip_line & (H_out == SKIP_AT);
  assign skip_jump = skip_hit & ~SKIP_ENDS_LINE;
  assign skip_end  = skip_hit & SKIP_ENDS_LINE;
  assign h_last    = (H_out == H_LAST) | skip_end;

  assign HEND = h_last;
  assign VEND = h_last & (V_out == V_LAST);

  hv_wrap_counter #(.LIMIT(H_TOTAL - 1)) u_h (
    .clk      (PCLK),
    .rst      (RES),
    .clr      (HC | skip_end),
    .load     (skip_jump),
    .load_val (SKIP_TO),
    .inc      (1'b1),
    .value    (H_out),
    .wrap     (unused_h_wrap)
  );

  // HC is a forced end of line, so V advances on it exactly as on a natural wrap.
  hv_wrap_counter #(.LIMIT(V_TOTAL - 1)) u_v (
    .clk      (PCLK),
    .rst      (RES),
    .clr      (VC),
    .load     (1'b0),
    .load_val ('0),
    .inc      (h_last | HC),
    .value    (V_out),
    .wrap     (v_wrap)
  );

  always_ff @(posedge PCLK) begin
    if (RES) begin
      ODD <= 1'b0;
    end else if (v_wrap) begin
      ODD <= ~ODD;
    end
  end

endmodule

// File: tb/tb_hv_counters.sv
// tb/tb_hv_counters.sv - scoreboard bench for hv_counters (expectations follow HV_ODD_SKIP_EN)
module tb_hv_counters;

  logic       PCLK = 1'b0;
  logic       RES  = 1'b1;
  logic       HC   = 1'b0;
  logic       VC   = 1'b0;
  logic       BLNK = 1'b0;
  logic [8:0] H_out;
  logic [8:0] V_out;
  logic       ODD;
  logic       HEND;
  logic       VEND;

  hv_counters dut (
    .PCLK  (PCLK),
    .RES   (RES),
    .HC    (HC),
    .VC    (VC),
    .BLNK  (BLNK),
    .H_out (H_out),
    .V_out (V_out),
    .ODD   (ODD),
    .HEND  (HEND),
    .VEND  (VEND)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int    cyc;
    bit    cnt;
    int    h;
    int    v;
    bit    odd;
    bit    hend;
    bit    vend;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   vend_cnt = 0;
  bit   done     = 1'b0;

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic expect_st(input string name, input int h, input int v,
                           input bit odd, input bit hend, input bit vend);
    exp_t e;
    e.cyc = cyc; e.cnt = 1'b0; e.h = h; e.v = v;
    e.odd = odd; e.hend = hend; e.vend = vend; e.name = name;
    q.push_back(e);
  endtask

  task automatic expect_vend(input string name, input int n);
    exp_t e;
    e.cyc = cyc; e.cnt = 1'b1; e.h = n; e.v = 0;
    e.odd = 1'b0; e.hend = 1'b0; e.vend = 1'b0; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: samples on the falling edge and retires every expectation due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (VEND) vend_cnt++;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          failures++;
          $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end else if (e.cnt) begin
          if (vend_cnt != e.h) begin
            failures++;
            $display("FAIL %s: vend pulses %0d, required %0d", e.name, vend_cnt, e.h);
          end
        end else if (int'(H_out) != e.h || int'(V_out) != e.v || ODD !== e.odd ||
                     HEND !== e.hend || VEND !== e.vend) begin
          failures++;
          $display("FAIL %s: got H=%0d V=%0d ODD=%0b HEND=%0b VEND=%0b, required H=%0d V=%0d ODD=%0b HEND=%0b VEND=%0b",
                   e.name, H_out, V_out, ODD, HEND, VEND, e.h, e.v, e.odd, e.hend, e.vend);
        end
      end
      if (done) begin
        checks++;
        if (q.size() != 0) begin
          failures++;
          $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: bench still running at time %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(2);
    RES = 1'b0;
    expect_st("reset", 0, 0, 1'b0, 1'b0, 1'b0);

    // First line dot by dot, then the end of the first frame.
    for (int k = 1; k <= 341; k++) begin
      tick(1);
      if (k == 341) expect_st("line0_wrap", 0, 1, 1'b0, 1'b0, 1'b0);
      else          expect_st("line0_dot", k, 0, 1'b0, (k == 340), 1'b0);
    end
    tick(89341 - 341);
    expect_st("frame_last_dot", 340, 261, 1'b0, 1'b1, 1'b1);
    tick(1);
    expect_st("frame_wrap", 0, 0, 1'b1, 1'b0, 1'b0);
    expect_vend("vend_once", 1);

    // Odd frame, rendering on: line 261 is where the dot skip applies.
    HC = 1'b1; tick(260);
    expect_st("odd_ff", 0, 260, 1'b1, 1'b0, 1'b0);
    HC = 1'b0; tick(341);
    expect_st("odd_l261", 0, 261, 1'b1, 1'b0, 1'b0);
    tick(338);
    expect_st("odd_338", 338, 261, 1'b1, 1'b0, 1'b0);
`ifdef HV_ODD_SKIP_EN
    tick(1);
    expect_st("skip_340", 340, 261, 1'b1, 1'b1, 1'b1);
    tick(1);
    expect_st("skip_wrap", 0, 0, 1'b0, 1'b0, 1'b0);
`else
    tick(1);
    expect_st("noskip_339", 339, 261, 1'b1, 1'b0, 1'b0);
    tick(1);
    expect_st("noskip_340", 340, 261, 1'b1, 1'b1, 1'b1);
    tick(1);
    expect_st("noskip_wrap", 0, 0, 1'b0, 1'b0, 1'b0);
`endif

    // Even frame never skips.
    HC = 1'b1; tick(261);
    expect_st("even_ff", 0, 261, 1'b0, 1'b0, 1'b0);
    HC = 1'b0; tick(339);
    expect_st("even_339", 339, 261, 1'b0, 1'b0, 1'b0);
    tick(1);
    expect_st("even_340", 340, 261, 1'b0, 1'b1, 1'b1);
    tick(1);
    expect_st("even_wrap", 0, 0, 1'b1, 1'b0, 1'b0);

    // Odd frame with rendering disabled never skips.
    BLNK = 1'b1; HC = 1'b1; tick(261);
    expect_st("blnk_ff", 0, 261, 1'b1, 1'b0, 1'b0);
    HC = 1'b0; tick(339);
    expect_st("blnk_339", 339, 261, 1'b1, 1'b0, 1'b0);
    tick(1);
    expect_st("blnk_340", 340, 261, 1'b1, 1'b1, 1'b1);
    tick(1);
    expect_st("blnk_wrap", 0, 0, 1'b0, 1'b0, 1'b0);
    BLNK = 1'b0;

    // HC mid-line is a forced end of line.
    HC = 1'b1; tick(5);
    expect_st("hc_ff", 0, 5, 1'b0, 1'b0, 1'b0);
    HC = 1'b0; tick(100);
    expect_st("hc_pre", 100, 5, 1'b0, 1'b0, 1'b0);
    HC = 1'b1; tick(1);
    expect_st("hc_clear", 0, 6, 1'b0, 1'b0, 1'b0);
    tick(255);
    expect_st("hc_261", 0, 261, 1'b0, 1'b0, 1'b0);
    VC = 1'b1; tick(1);
    expect_st("hc_vc_no_toggle", 0, 0, 1'b0, 1'b0, 1'b0);
    HC = 1'b0; VC = 1'b0; tick(50);
    expect_st("run50", 50, 0, 1'b0, 1'b0, 1'b0);
    HC = 1'b1; tick(3);
    expect_st("hc_v3", 0, 3, 1'b0, 1'b0, 1'b0);
    HC = 1'b0; tick(20);
    expect_st("vc_pre", 20, 3, 1'b0, 1'b0, 1'b0);
    VC = 1'b1; tick(1);
    expect_st("vc_only", 21, 0, 1'b0, 1'b0, 1'b0);
    VC = 1'b0;

    // Reset mid-frame on an odd frame.
    HC = 1'b1; tick(412);
    expect_st("res_ff", 0, 150, 1'b1, 1'b0, 1'b0);
    HC = 1'b0; tick(200);
    expect_st("res_pre", 200, 150, 1'b1, 1'b0, 1'b0);
    RES = 1'b1; tick(1);
    expect_st("res_mid", 0, 0, 1'b0, 1'b0, 1'b0);
    RES = 1'b0; tick(1);
    expect_st("res_after", 1, 0, 1'b0, 1'b0, 1'b0);
    tick(2);
    done = 1'b1;
  end

endmodule

// File: doc/hv_counters.md
Name: hv_counters

Overview:
- Upstream stage of the PPU H/V decoder: generates the 9-bit horizontal (dot) and vertical (line) counters that drive the decoder's H and V inputs.
- Free-running raster timing with frame-parity tracking and optional odd-frame dot skip.
- Synchronous override clears let the downstream timing FSM force realignment.
- One instance per PPU, in the PCLK domain.

Parameters:
- H_TOTAL, 341, dots per line (legal range 2..512); H counts 0..H_TOTAL-1.
- V_TOTAL, 262, lines per frame (legal range 2..512); use 312 for RP2C07 builds.
- SKIP_H, 339, dot removed on the skipped line: H jumps from SKIP_H-1 to 0 (legal range 1..H_TOTAL-1).

Ports:
- PCLK  in  1  PPU pixel clock; all state updates on the rising edge.
- RES  in  1  synchronous, active-high reset.
- HC  in  1  synchronous H clear request from the timing FSM.
- VC  in  1  synchronous V clear request from the timing FSM.
- BLNK  in  1  rendering disabled (1) / enabled (0); gates the dot skip.
- H_out  out  9  horizontal counter, registered.
- V_out  out  9  vertical counter, registered.
- ODD  out  1  frame parity, registered: 0 = even frame, 1 = odd frame.
- HEND  out  1  combinational: high during the last dot of the current line.
- VEND  out  1  combinational: HEND and V_out==V_TOTAL-1 (last dot of the frame).

Behaviour:
- Reset, taking priority over everything: H_out=0, V_out=0, ODD=0, on the edge where RES=1. HEND/VEND then follow from the reset state, so both are 0 (H=0).
- Skip condition: skip_line = (V_out==V_TOTAL-1) & ODD & ~BLNK. BLNK is sampled every cycle; no latching.
- Last dot of the line: h_last = skip_line ? (H_out==SKIP_H-1) : (H_out==H_TOTAL-1). HEND = h_last.
- H update per cycle, priority order:
  - RES → 0.
  - HC → 0.
  - h_last → 0.
  - otherwise H+1.
- V update, only on a cycle with h_last=1 or HC=1:
  - RES → 0.
  - VC → 0.
  - V==V_TOTAL-1 → 0 and ODD toggles.
  - otherwise V+1.
- VC asserted without h_last/HC also clears V immediately; VC alone never toggles ODD.
- HC acts as a forced end of line: V advances exactly as on a natural wrap.
- HC and VC together → H=0, V=0, ODD unchanged.
- No pipeline latency: a clear asserted on edge n is visible on H_out/V_out after edge n.
- Normal wrap adds no extra cycle: H goes …,H_TOTAL-1,0,…
- Skipped line length is SKIP_H dots, but the counter still reaches H_TOTAL-1 via the jump. Concretely: dot SKIP_H-1 is followed by H=0 on the next line, so dots SKIP_H..H_TOTAL-1 never occur on that line.
  - NTSC correction: the canonical skip removes dot 339 only. The required H sequence on a skipped line is …,338,340,0. Replace the rule above with: when skip_line & H_out==SKIP_H-1, then H ← SKIP_H+1. In that case h_last is the normal H_TOTAL-1 test, so the line is H_TOTAL-1 dots long.
- BLNK toggling mid-line takes effect on the next evaluated cycle.
- Out-of-range counter values can only come from illegal parameters; behaviour for those is undefined. Assertion checks are for the bench only.

Optional Feature:
- Macro HV_ODD_SKIP_EN.
- Defined: odd-frame dot skip as specified above.
- Undefined: skip_line is tied 0. Every line is H_TOTAL dots, and ODD still toggles per frame.
- PAL (RP2C07) builds leave HV_ODD_SKIP_EN undefined.

Decomposition:
- Shared package hv_pkg holds:
  - HV_W=9.
  - NTSC_H_TOTAL=341, NTSC_V_TOTAL=262.
  - PAL_H_TOTAL=341, PAL_V_TOTAL=312.
  - NTSC_SKIP_H=339.
- One sub-module, hv_wrap_counter: a 9-bit counter with inc, clr, load-value and wrap-at-limit.
  - Instantiated once for H (with the skip load) and once for V (with a wrap strobe that toggles ODD).

Test Plan:
- Reset then run 341 cycles, HV_ODD_SKIP_EN off → H 0..340, HEND high only at H=340, V=1 after cycle 341.
- Full frame with skip off → V wraps 261→0 after 89342 cycles, ODD 0→1, VEND pulses once.
- Skip on, BLNK=0, second frame (ODD=1), line 261 → H sequence 338,340,0. Frame is 89341 cycles; the next even frame is 89342.
- Skip on, BLNK=1 on an odd frame → no skip, frame is 89342 cycles.
- HC at H=100, V=5 → next H=0, V=6. HC+VC together → H=0, V=0, ODD unchanged.
- RES asserted at H=200, V=150, ODD=1 → next cycle H=0, V=0, ODD=0, HEND=VEND=0.
